// File: rtl/pfpu_vdma_pkg.sv
// Shared PFPU definitions for the vertex DMA writer: the Wishbone select
// constant, the WORDS range check, the log2 helper used for byte-shift
// computation, and the writer state encoding.
package pfpu_vdma_pkg;

  // All writes are full 32-bit words.
  localparam logic [3:0] WB_SEL = 4'hF;

  // Smallest r with 2**r >= v. Used for pointer widths and byte shifts.
  function automatic int unsigned vdma_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // WORDS must be a power of two in 1..8.
  function automatic bit words_valid(input int unsigned w);
    return (w >= 1) && (w <= 8) && ((w & (w - 1)) == 0);
  endfunction

  // FIFO_DEPTH must be a power of two, at least 2.
  function automatic bit depth_valid(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } vdma_state_e;

endpackage

// File: rtl/pfpu_vdma_if.sv
// Write-only Wishbone master bus of the vertex DMA writer.
//   wbm_adr_o  : word write address
//   wbm_dat_o  : write data
//   wbm_sel_o  : byte select, always 1111
//   wbm_cyc_o  : bus cycle
//   wbm_stb_o  : strobe
//   wbm_ack_i  : slave acknowledge
interface pfpu_vdma_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i
  );
endinterface

// File: rtl/pfpu_vdma_fifo.sv
// Synchronous-write, asynchronous-read FIFO for vertex entries.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write wdata (ignored while full)
//   pop       : drop the head entry (ignored while empty)
//   full      : registered, count == DEPTH
//   empty_c   : combinational, no entries stored
//   count_c   : combinational entry count
//   head_c    : combinational head entry
//   second_c  : combinational entry behind the head
module pfpu_vdma_fifo
  import pfpu_vdma_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty_c,
  output logic [vdma_log2(DEPTH):0]   count_c,
  output logic [WIDTH-1:0]            head_c,
  output logic [WIDTH-1:0]            second_c
);

  localparam int unsigned AW = vdma_log2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count_nxt;
  logic             wr_en;
  logic             rd_en;

  assign wr_en     = push & ~full;
  assign rd_en     = pop & ~empty_c;
  assign count_c   = wr_ptr - rd_ptr;
  assign empty_c   = (wr_ptr == rd_ptr);
  assign head_c    = mem[rd_ptr[AW-1:0]];
  assign second_c  = mem[AW'(rd_ptr[AW-1:0] + 1'b1)];
  assign count_nxt = count_c + PW'(wr_en) - PW'(rd_en);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointers wrap naturally; full is registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      full <= (count_nxt == PW'(DEPTH));
    end
  end

endmodule

// File: rtl/pfpu_vdma.sv
// Parametrised PFPU vertex DMA writer. Buffers one vertex per strobe in a
// FIFO and writes its WORDS words to memory at a mesh-linear address over a
// write-only Wishbone master.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   in_stb/x/y/d     : vertex push (coordinates + WORDS data words)
//   dma_base         : byte base address (low log2(4*WORDS) bits ignored)
//   full             : FIFO full, sequencer must not strobe
//   idle             : FIFO empty and master idle
//   vdone            : one-cycle pulse per vertex written
//   err_overflow     : sticky, strobe while full; err_clr clears it
//   wb               : Wishbone master bus
module pfpu_vdma
  import pfpu_vdma_pkg::*;
#(
  parameter int unsigned WORDS      = 2,
  parameter int unsigned MESH_BITS  = 7,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   in_stb,
  input  logic [MESH_BITS-1:0]   in_x,
  input  logic [MESH_BITS-1:0]   in_y,
  input  logic [32*WORDS-1:0]    in_d,
  input  logic [31:0]            dma_base,
  output logic                   full,
  output logic                   idle,
  output logic                   vdone,
  output logic                   err_overflow,
  input  logic                   err_clr,
  pfpu_vdma_if.master            wb
);

  localparam int unsigned DW    = 32 * WORDS;
  localparam int unsigned EW    = 2 * MESH_BITS + DW;
  localparam int unsigned SHIFT = vdma_log2(4 * WORDS);
  localparam int unsigned KW    = (WORDS > 1) ? vdma_log2(WORDS) : 1;
  localparam int unsigned PW    = vdma_log2(FIFO_DEPTH) + 1;
  localparam logic [KW-1:0] K_LAST   = KW'(WORDS - 1);
  localparam logic [31:0]   ADR_MASK = ~32'(4 * WORDS - 1);

  if (!words_valid(WORDS)) begin : g_bad_words
    $error("pfpu_vdma: WORDS must be a power of two in 1..8");
  end
  if (!depth_valid(FIFO_DEPTH)) begin : g_bad_depth
    $error("pfpu_vdma: FIFO_DEPTH must be a power of two >= 2");
  end

  vdma_state_e   state;
  logic [KW-1:0] k;

  logic          push;
  logic          ack_ok;
  logic          last_ack;
  logic          fifo_empty;
  logic [PW-1:0] fifo_count;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head;
  logic [EW-1:0] second;
  logic [EW-1:0] next_entry;
  logic          have_next;

  // Entry layout {y, x, d}: the top 2*MESH_BITS bits are already y<<MESH_BITS | x.
  assign in_entry = {in_y, in_x, in_d};
  assign push     = in_stb & ~full;
  assign ack_ok   = wb.wbm_stb_o & wb.wbm_ack_i;
  assign last_ack = (state == S_WRITE) && ack_ok && (k == K_LAST);

  // Entry that follows the head once it is popped; a same-cycle push into a
  // one-entry FIFO is forwarded so back-to-back vertices have no bubble.
  assign have_next  = (fifo_count > PW'(1)) || push;
  assign next_entry = (fifo_count > PW'(1)) ? second : in_entry;

  assign wb.wbm_sel_o = WB_SEL;

  pfpu_vdma_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .push     (push),
    .wdata    (in_entry),
    .pop      (last_ack),
    .full     (full),
    .empty_c  (fifo_empty),
    .count_c  (fifo_count),
    .head_c   (head),
    .second_c (second)
  );

  // Byte address of beat kk of entry e, modulo 2^32.
  function automatic logic [31:0] beat_adr(input logic [31:0]   base,
                                           input logic [EW-1:0] e,
                                           input logic [KW-1:0] kk);
    logic [31:0] idx;
    idx = 32'(e[EW-1:DW]);
    return (base & ADR_MASK) + (idx << SHIFT) + (32'(kk) << 2);
  endfunction

  function automatic logic [31:0] beat_dat(input logic [EW-1:0] e,
                                           input logic [KW-1:0] kk);
    return e[{kk, 5'b0} +: 32];
  endfunction

  // Writer FSM with registered bus outputs and status flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      k            <= '0;
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      wb.wbm_adr_o <= '0;
      wb.wbm_dat_o <= '0;
      vdone        <= 1'b0;
      idle         <= 1'b1;
      err_overflow <= 1'b0;
    end else begin
      vdone <= 1'b0;
      idle  <= (state == S_IDLE) && fifo_empty && !push;

      // A dropped strobe wins over a simultaneous clear.
      if (in_stb && full)  err_overflow <= 1'b1;
      else if (err_clr)    err_overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state        <= S_WRITE;
            k            <= '0;
            wb.wbm_cyc_o <= 1'b1;
            wb.wbm_stb_o <= 1'b1;
            wb.wbm_adr_o <= beat_adr(dma_base, head, '0);
            wb.wbm_dat_o <= beat_dat(head, '0);
          end
        end
        S_WRITE: begin
          if (ack_ok) begin
            if (k != K_LAST) begin
              k            <= KW'(k + 1'b1);
              wb.wbm_adr_o <= beat_adr(dma_base, head, KW'(k + 1'b1));
              wb.wbm_dat_o <= beat_dat(head, KW'(k + 1'b1));
            end else begin
              vdone <= 1'b1;
              k     <= '0;
              if (have_next) begin
                wb.wbm_adr_o <= beat_adr(dma_base, next_entry, '0);
                wb.wbm_dat_o <= beat_dat(next_entry, '0);
              end else begin
                state        <= S_IDLE;
                wb.wbm_cyc_o <= 1'b0;
                wb.wbm_stb_o <= 1'b0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pfpu_vdma.sv
// Directed self-checking bench for pfpu_vdma: table of single-vertex
// transfers plus hand-written stall/overflow/back-to-back, reset and
// parametric (WORDS=4, MESH_BITS=5) sequences.
module tb_pfpu_vdma;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  // Default instance: WORDS=2, MESH_BITS=7, FIFO_DEPTH=8
  logic        in_stb;
  logic [6:0]  in_x, in_y;
  logic [63:0] in_d;
  logic [31:0] dma_base;
  logic        full, idle, vdone, err_overflow, err_clr;
  logic        ack_en;
  pfpu_vdma_if wb();
  assign wb.wbm_ack_i = wb.wbm_stb_o & ack_en;

  pfpu_vdma #(.WORDS(2), .MESH_BITS(7), .FIFO_DEPTH(8)) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .in_stb       (in_stb),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_d         (in_d),
    .dma_base     (dma_base),
    .full         (full),
    .idle         (idle),
    .vdone        (vdone),
    .err_overflow (err_overflow),
    .err_clr      (err_clr),
    .wb           (wb)
  );

  // Parametric instance: WORDS=4, MESH_BITS=5, FIFO_DEPTH=4, zero-wait ack
  logic         p_in_stb;
  logic [4:0]   p_in_x, p_in_y;
  logic [127:0] p_in_d;
  logic [31:0]  p_dma_base;
  logic         p_full, p_idle, p_vdone, p_err_overflow, p_err_clr;
  pfpu_vdma_if  pwb();
  assign pwb.wbm_ack_i = pwb.wbm_stb_o;

  pfpu_vdma #(.WORDS(4), .MESH_BITS(5), .FIFO_DEPTH(4)) u_dut_p (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .in_stb       (p_in_stb),
    .in_x         (p_in_x),
    .in_y         (p_in_y),
    .in_d         (p_in_d),
    .dma_base     (p_dma_base),
    .full         (p_full),
    .idle         (p_idle),
    .vdone        (p_vdone),
    .err_overflow (p_err_overflow),
    .err_clr      (p_err_clr),
    .wb           (pwb)
  );

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vecs[5];

  int beats, dones, cyc_low, stale;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{32'h4000_0000, 7'd3,   7'd2,   32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h4000_0818, 32'h4000_081C};
    vecs[1] = '{32'h4000_0007, 7'd0,   7'd0,   32'h0000_0001, 32'h0000_0002, 32'h4000_0000, 32'h4000_0004};
    vecs[2] = '{32'h1234_567F, 7'd127, 7'd0,   32'hCAFE_F00D, 32'h1357_9BDF, 32'h1234_5A70, 32'h1234_5A74};
    vecs[3] = '{32'hFFFF_FFF8, 7'd127, 7'd127, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0001_FFF0, 32'h0001_FFF4};
    vecs[4] = '{32'h0000_0000, 7'd0,   7'd1,   32'h5555_5555, 32'h6666_6666, 32'h0000_0400, 32'h0000_0404};

    in_stb = 0; in_x = '0; in_y = '0; in_d = '0; dma_base = '0; err_clr = 0; ack_en = 0;
    p_in_stb = 0; p_in_x = '0; p_in_y = '0; p_in_d = '0; p_dma_base = '0; p_err_clr = 0;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();

    // Reset state
    check("rst_full",  full, 0);
    check("rst_idle",  idle, 1);
    check("rst_vdone", vdone, 0);
    check("rst_err",   err_overflow, 0);
    check("rst_cyc",   wb.wbm_cyc_o, 0);
    check("rst_stb",   wb.wbm_stb_o, 0);
    check("rst_adr",   wb.wbm_adr_o, 0);
    check("rst_dat",   wb.wbm_dat_o, 0);
    check("sel",       wb.wbm_sel_o, 32'hF);

    // Single-vertex table, zero-wait ack; push in cycle 0
    ack_en = 1;
    for (int i = 0; i < 5; i++) begin
      dma_base = vecs[i].base;
      in_x = vecs[i].x; in_y = vecs[i].y; in_d = {vecs[i].d1, vecs[i].d0};
      in_stb = 1;
      tick();                       // cycle 1
      in_stb = 0;
      check($sformatf("v%0d_stb_c1", i), wb.wbm_stb_o, 0);
      tick();                       // cycle 2
      check($sformatf("v%0d_stb_c2", i), wb.wbm_stb_o, 1);
      check($sformatf("v%0d_adr0", i), wb.wbm_adr_o, vecs[i].a0);
      check($sformatf("v%0d_dat0", i), wb.wbm_dat_o, vecs[i].d0);
      tick();                       // cycle 3
      check($sformatf("v%0d_adr1", i), wb.wbm_adr_o, vecs[i].a1);
      check($sformatf("v%0d_dat1", i), wb.wbm_dat_o, vecs[i].d1);
      check($sformatf("v%0d_vdone_c3", i), vdone, 0);
      tick();                       // cycle 4
      check($sformatf("v%0d_vdone_c4", i), vdone, 1);
      check($sformatf("v%0d_cyc_c4", i), wb.wbm_cyc_o, 0);
      check($sformatf("v%0d_idle_c4", i), idle, 0);
      tick();                       // cycle 5
      check($sformatf("v%0d_vdone_c5", i), vdone, 0);
      check($sformatf("v%0d_idle_c5", i), idle, 1);
    end

    // Stalled slave: 8 pushes fill the FIFO while word 0 is held
    ack_en = 0;
    dma_base = 32'h4000_0000;
    for (int i = 0; i < 8; i++) begin
      in_stb = 1;
      in_x = (i < 4) ? 7'(124 + i) : 7'(i - 4);
      in_y = (i < 4) ? 7'd5 : 7'd6;
      in_d = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
      tick();                       // cycle i+1
      check($sformatf("stall_full_%0d", i), full, (i == 7) ? 1 : 0);
      if (i >= 1) begin
        check($sformatf("stall_stb_%0d", i), wb.wbm_stb_o, 1);
        check($sformatf("stall_adr_%0d", i), wb.wbm_adr_o, 32'h4000_17E0);
        check($sformatf("stall_dat_%0d", i), wb.wbm_dat_o, 32'hA000_0000);
      end
    end

    // Overflow: dropped vertex, then clear, then clear racing a new overflow
    in_stb = 1; in_x = 7'd50; in_y = 7'd50; in_d = {2{32'hDEAD_BEEF}};
    tick();
    check("ovf_set", err_overflow, 1);
    check("ovf_full", full, 1);
    in_stb = 0; err_clr = 1;
    tick();
    check("ovf_clr", err_overflow, 0);
    in_stb = 1;
    tick();
    check("ovf_clr_vs_set", err_overflow, 1);
    check("ovf_full2", full, 1);
    in_stb = 0;
    tick();
    check("ovf_clr2", err_overflow, 0);
    err_clr = 0;

    // Release: 16 contiguous beats across the x=127 -> 0, y+1 wrap
    ack_en = 1;
    beats = 0; dones = 0; cyc_low = 0;
    for (int c = 0; c < 40 && dones < 8; c++) begin
      if (wb.wbm_cyc_o !== 1'b1) cyc_low++;
      if (wb.wbm_stb_o) begin
        check($sformatf("b2b_adr_%0d", beats), wb.wbm_adr_o, 32'h4000_17E0 + 32'(4 * beats));
        check($sformatf("b2b_dat_%0d", beats), wb.wbm_dat_o,
              (((beats % 2) != 0) ? 32'hB000_0000 : 32'hA000_0000) | 32'(beats / 2));
        beats++;
      end
      tick();
      if (vdone) dones++;
    end
    check("b2b_vdones", 32'(dones), 8);
    check("b2b_beats", 32'(beats), 16);
    check("b2b_cyc_drops", 32'(cyc_low), 0);
    check("b2b_stb_after", wb.wbm_stb_o, 0);
    check("b2b_full_after", full, 0);
    tick();
    check("b2b_idle", idle, 1);
    stale = 0;
    repeat (4) begin
      tick();
      if (wb.wbm_stb_o) stale++;
    end
    check("b2b_no_dropped_vertex", 32'(stale), 0);

    // Async reset mid-beat 1 with a second vertex queued
    dma_base = 32'h0;
    in_x = 7'd1; in_y = 7'd1; in_d = {32'h0000_0002, 32'h0000_0001};
    in_stb = 1;
    tick();                         // cycle 1
    in_x = 7'd2;
    tick();                         // cycle 2: beat 0
    in_stb = 0;
    tick();                         // cycle 3: beat 1
    ack_en = 0;
    check("rmid_stb", wb.wbm_stb_o, 1);
    check("rmid_adr1", wb.wbm_adr_o, 32'h0000_040C);
    check("rmid_dat1", wb.wbm_dat_o, 32'h0000_0002);
    #2 sys_rst = 1'b1;
    #1;
    check("rmid_cyc_async", wb.wbm_cyc_o, 0);
    check("rmid_stb_async", wb.wbm_stb_o, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    ack_en = 1;
    tick();
    check("rmid_idle", idle, 1);
    check("rmid_full", full, 0);
    stale = 0;
    repeat (8) begin
      tick();
      if (wb.wbm_stb_o || wb.wbm_cyc_o) stale++;
    end
    check("rmid_no_stale", 32'(stale), 0);

    // Parametric instance: address wraps mod 2^32, low base bits masked
    p_dma_base = 32'hFFFF_FFF7;
    p_in_x = 5'd31; p_in_y = 5'd31;
    p_in_d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    p_in_stb = 1;
    tick();                         // cycle 1
    p_in_stb = 0;
    check("p_stb_c1", pwb.wbm_stb_o, 0);
    tick();                         // cycle 2
    for (int k = 0; k < 4; k++) begin
      check($sformatf("p_stb_%0d", k), pwb.wbm_stb_o, 1);
      check($sformatf("p_adr_%0d", k), pwb.wbm_adr_o, 32'h0000_3FE0 + 32'(4 * k));
      check($sformatf("p_dat_%0d", k), pwb.wbm_dat_o, 32'(32'h1111_1111 * (k + 1)));
      tick();
    end
    check("p_vdone", p_vdone, 1);
    check("p_full", p_full, 0);
    tick();
    check("p_idle", p_idle, 1);
    check("p_err", p_err_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
